// File: rtl/register_file.sv
// register_file
//   32 x 32-bit RV32I integer register file (x0..x31) with two combinational
//   read ports and one synchronous write port. x0 has no storage and always
//   reads zero. Reads never forward same-cycle write data; hazards are
//   resolved by the pipeline.
//
// Ports
//   i_clk     clock; state updates on the rising edge
//   i_rst_n   asynchronous active-low reset; clears x1..x31
//   i_Rnum1   read port 1 index (rs1)
//   i_Rnum2   read port 2 index (rs2)
//   i_Wen     write enable, sampled at the rising edge
//   i_Wnum    write index (rd); writes to index 0 are dropped
//   i_Wd      write data
//   o_Rd1     contents of register i_Rnum1 (0 for index 0)
//   o_Rd2     contents of register i_Rnum2 (0 for index 0)
module register_file #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [ADDR_WIDTH-1:0] i_Rnum1,
    input  logic [ADDR_WIDTH-1:0] i_Rnum2,
    input  logic                  i_Wen,
    input  logic [ADDR_WIDTH-1:0] i_Wnum,
    input  logic [DATA_WIDTH-1:0] i_Wd,
    output logic [DATA_WIDTH-1:0] o_Rd1,
    output logic [DATA_WIDTH-1:0] o_Rd2
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    // Storage starts at index 1: x0 is implied by the read mux defaults.
    logic [DATA_WIDTH-1:0] regs_q [1:DEPTH-1];
    logic [DATA_WIDTH-1:0] regs_d [1:DEPTH-1];

    always_comb begin
        for (int unsigned i = 1; i < DEPTH; i++) begin
            regs_d[i] = regs_q[i];
            if (i_Wen && (i_Wnum == ADDR_WIDTH'(i))) begin
                regs_d[i] = i_Wd;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned i = 1; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 1; i < DEPTH; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Read muxes default to zero, which covers index 0 without storage.
    always_comb begin
        o_Rd1 = '0;
        o_Rd2 = '0;
        for (int unsigned i = 1; i < DEPTH; i++) begin
            if (i_Rnum1 == ADDR_WIDTH'(i)) begin
                o_Rd1 = regs_q[i];
            end
            if (i_Rnum2 == ADDR_WIDTH'(i)) begin
                o_Rd2 = regs_q[i];
            end
        end
    end

endmodule

// File: tb/tb_register_file.sv
module tb_register_file;

    logic        clk;
    logic        rst_n;
    logic [4:0]  rnum1;
    logic [4:0]  rnum2;
    logic        wen;
    logic [4:0]  wnum;
    logic [31:0] wd;
    logic [31:0] rd1;
    logic [31:0] rd2;

    int checks = 0;
    int errors = 0;

    // Reference contents: entry 0 is never written, so it stays zero.
    logic [31:0] model [32];

    register_file #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(5)
    ) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .i_Rnum1(rnum1),
        .i_Rnum2(rnum2),
        .i_Wen  (wen),
        .i_Wnum (wnum),
        .i_Wd   (wd),
        .o_Rd1  (rd1),
        .o_Rd2  (rd2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Apply a write at the next rising edge and update the model as the spec says.
    task automatic do_write(input logic [4:0] idx, input logic [31:0] data);
        @(negedge clk);
        wen  = 1'b1;
        wnum = idx;
        wd   = data;
        @(posedge clk);
        if (idx != 5'd0) model[idx] = data;
        #1;
        wen = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 32; i++) model[i] = '0;
        for (int i = 0; i < 32; i++) begin
            rnum1 = 5'(i);
            rnum2 = 5'(31 - i);
            #1;
            checks++;
            if (rd1 !== 32'd0 || rd2 !== 32'd0) begin
                errors++;
                $display("FAIL reset_sweep idx=%0d rd1=%h rd2=%h expected 0", i, rd1, rd2);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_x0_write;
        do_write(5'd0, 32'hDEADBEEF);
        rnum1 = 5'd0;
        #1;
        checks++;
        if (rd1 !== 32'd0) begin
            errors++;
            $display("FAIL x0_write rd1=%h expected 0", rd1);
        end
    endtask

    task automatic test_sweep;
        for (int i = 1; i < 32; i++) do_write(5'(i), 32'(i));
        wen = 1'b0;
        for (int i = 0; i < 32; i++) begin
            for (int j = 0; j < 32; j++) begin
                rnum1 = 5'(i);
                rnum2 = 5'(j);
                #1;
                checks++;
                if (rd1 !== 32'(i) || rd2 !== 32'(j)) begin
                    errors++;
                    $display("FAIL pair_sweep r1=%0d r2=%0d got %h/%h expected %h/%h",
                             i, j, rd1, rd2, 32'(i), 32'(j));
                end
            end
        end
    endtask

    task automatic test_same_cycle;
        @(negedge clk);
        rnum1 = 5'd5;
        rnum2 = 5'd5;
        wnum  = 5'd5;
        wd    = 32'h1F;
        wen   = 1'b1;
        #1;
        checks++;
        if (rd1 !== 32'd5 || rd2 !== 32'd5) begin
            errors++;
            $display("FAIL same_cycle_before rd1=%h rd2=%h expected 5", rd1, rd2);
        end
        @(posedge clk);
        model[5] = 32'h1F;
        #1;
        wen = 1'b0;
        checks++;
        if (rd1 !== 32'h1F || rd2 !== 32'h1F) begin
            errors++;
            $display("FAIL same_cycle_after rd1=%h rd2=%h expected 1f", rd1, rd2);
        end
    endtask

    task automatic test_wen_gating;
        @(negedge clk);
        wen   = 1'b0;
        wnum  = 5'd7;
        wd    = 32'hFFFF_FFFF;
        rnum1 = 5'd7;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            checks++;
            if (rd1 !== 32'd7) begin
                errors++;
                $display("FAIL wen_gating cycle=%0d rd1=%h expected 7", c, rd1);
            end
        end
    endtask

    task automatic test_dual_port;
        do_write(5'd31, 32'hA5A5A5A5);
        rnum1 = 5'd31;
        rnum2 = 5'd31;
        #1;
        checks++;
        if (rd1 !== 32'hA5A5A5A5 || rd2 !== 32'hA5A5A5A5) begin
            errors++;
            $display("FAIL dual_port rd1=%h rd2=%h expected a5a5a5a5", rd1, rd2);
        end
    endtask

    // Random traffic: each cycle check reads before the edge (old value) and after it (new value).
    task automatic test_random;
        logic [31:0] e1, e2;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            wen   = 1'($urandom_range(0, 1));
            wnum  = 5'($urandom_range(0, 31));
            wd    = $urandom;
            rnum1 = ($urandom_range(0, 3) == 0) ? wnum : 5'($urandom_range(0, 31));
            rnum2 = ($urandom_range(0, 3) == 0) ? wnum : 5'($urandom_range(0, 31));
            #1;
            e1 = model[rnum1];
            e2 = model[rnum2];
            checks++;
            if (rd1 !== e1 || rd2 !== e2) begin
                errors++;
                $display("FAIL random_pre n=%0d got %h/%h expected %h/%h", n, rd1, rd2, e1, e2);
            end
            @(posedge clk);
            if (wen && wnum != 5'd0) model[wnum] = wd;
            #1;
            e1 = model[rnum1];
            e2 = model[rnum2];
            checks++;
            if (rd1 !== e1 || rd2 !== e2) begin
                errors++;
                $display("FAIL random_post n=%0d got %h/%h expected %h/%h", n, rd1, rd2, e1, e2);
            end
        end
        wen = 1'b0;
    endtask

    task automatic test_async_reset;
        for (int i = 1; i < 32; i++) do_write(5'(i), 32'h1000_0000 + 32'(i));
        rnum1 = 5'd9;
        rnum2 = 5'd20;
        #1;
        checks++;
        if (rd1 !== 32'h1000_0009 || rd2 !== 32'h1000_0014) begin
            errors++;
            $display("FAIL preload rd1=%h rd2=%h expected 10000009/10000014", rd1, rd2);
        end
        @(negedge clk);
        #2 rst_n = 1'b0;
        for (int i = 0; i < 32; i++) model[i] = '0;
        #1;
        checks++;
        if (rd1 !== 32'd0 || rd2 !== 32'd0) begin
            errors++;
            $display("FAIL async_reset_drop rd1=%h rd2=%h expected 0", rd1, rd2);
        end
        wen  = 1'b1;
        wnum = 5'd9;
        wd   = 32'hCAFE_F00D;
        repeat (2) @(posedge clk);
        #1;
        wen = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) begin
            rnum1 = 5'(i);
            rnum2 = 5'(i ^ 9);
            #1;
            checks++;
            if (rd1 !== 32'd0 || rd2 !== 32'd0) begin
                errors++;
                $display("FAIL post_reset idx=%0d rd1=%h rd2=%h expected 0", i, rd1, rd2);
            end
        end
        do_write(5'd9, 32'h0BAD_C0DE);
        rnum1 = 5'd9;
        #1;
        checks++;
        if (rd1 !== 32'h0BAD_C0DE) begin
            errors++;
            $display("FAIL rewrite_after_reset rd1=%h expected 0badc0de", rd1);
        end
    endtask

    initial begin
        rst_n = 1'b1;
        rnum1 = '0;
        rnum2 = '0;
        wen   = 1'b0;
        wnum  = '0;
        wd    = '0;
        for (int i = 0; i < 32; i++) model[i] = '0;
        repeat (2) @(posedge clk);
        test_reset;
        test_x0_write;
        test_sweep;
        test_same_cycle;
        test_wen_gating;
        test_dual_port;
        test_random;
        test_async_reset;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
